tdm_nibble_rx: RTL and testbench

Receive end of the board's nibble time-division link. A transmitter sends one nibble per beat over a 4-bit valid/ready channel, with start-of-frame marking slot 0. This block reassembles the slots into a shadow register and commits a complete frame atomically to its held output, normally driven straight onto the 16 board LEDs. Partial, interrupted or corrupted frames never reach the output.

---
 rtl/tdm_pkg.sv | 18 +
 rtl/tdm_nibble_rx.sv | 110 +++++++++++
 tb/tb_tdm_nibble_rx.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the nibble TDM link: default geometry, receiver FSM
// states and the even-parity helper used by both ends of the link.
package tdm_pkg;

  localparam int unsigned TDM_SLOTS = 4;
  localparam int unsigned TDM_W     = 4;

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } tdm_state_e;

  // Zero-extension does not change even parity, so callers widen to 32 bits.
  function automatic logic tdm_parity(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/tdm_nibble_rx.sv
// Nibble TDM receiver: reassembles SLOTS beats into a shadow register and
// commits whole frames to led. Optional parity checking via TDM_RX_PARITY_EN.
module tdm_nibble_rx
  import tdm_pkg::*;
#(
  parameter int unsigned SLOTS = TDM_SLOTS,
  parameter int unsigned W     = TDM_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               rx_valid,
  input  logic               rx_sof,
  input  logic [W-1:0]       rx_data,
`ifdef TDM_RX_PARITY_EN
  input  logic               rx_par,
`endif
  output logic               rx_ready,
  output logic [SLOTS*W-1:0] led,
  output logic               frame_done,
  output logic               err
);

  localparam int unsigned CW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  tdm_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [SLOTS*W-1:0] shadow_q, shadow_d;
  logic [SLOTS*W-1:0] led_q, led_d;
  logic               frame_done_q, frame_done_d;
  logic               err_q, err_d;
  logic               accept;
  logic               par_err;

  assign rx_ready = en;
  assign accept   = rx_valid && en;

`ifdef TDM_RX_PARITY_EN
  assign par_err = (rx_par != tdm_parity(32'(rx_data)));
`else
  assign par_err = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    led_d        = led_q;
    frame_done_d = 1'b0;
    err_d        = 1'b0;

    if (accept) begin
      // A bad-parity beat only matters if it would have been taken; dropped
      // HUNT beats stay silent.
      if (par_err && (rx_sof || state_q == RECV)) begin
        err_d    = 1'b1;
        state_d  = HUNT;
        cnt_d    = '0;
        shadow_d = '0;
      end else if (state_q == HUNT) begin
        if (rx_sof) begin
          shadow_d          = '0;
          shadow_d[W-1:0]   = rx_data;
          cnt_d             = CW'(1);
          state_d           = RECV;
        end
      end else if (rx_sof) begin
        err_d           = 1'b1;
        shadow_d        = '0;
        shadow_d[W-1:0] = rx_data;
        cnt_d           = CW'(1);
      end else begin
        for (int unsigned i = 0; i < SLOTS; i++) begin
          if (cnt_q == CW'(i)) shadow_d[i*W +: W] = rx_data;
        end
        if (cnt_q == CW'(SLOTS - 1)) begin
          led_d        = shadow_d;
          frame_done_d = 1'b1;
          cnt_d        = '0;
          state_d      = HUNT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= HUNT;
      cnt_q        <= '0;
      shadow_q     <= '0;
      led_q        <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      led_q        <= led_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign led        = led_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_tdm_nibble_rx.sv
// Scoreboard bench for tdm_nibble_rx: stimulus pushes expected frame_done and
// err events (cycle + value); a negedge monitor pops and compares them.
module tb_tdm_nibble_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        rx_valid;
  logic        rx_sof;
  logic [3:0]  rx_data;
`ifdef TDM_RX_PARITY_EN
  logic        rx_par;
`endif
  logic        rx_ready;
  logic [15:0] led;
  logic        frame_done;
  logic        err;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc   = 0;

  typedef struct {
    int unsigned cyc;
    logic [15:0] led;
  } done_t;

  done_t       exp_done[$];
  int unsigned exp_err[$];

  tdm_nibble_rx #(.SLOTS(4), .W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .rx_valid   (rx_valid),
    .rx_sof     (rx_sof),
    .rx_data    (rx_data),
`ifdef TDM_RX_PARITY_EN
    .rx_par     (rx_par),
`endif
    .rx_ready   (rx_ready),
    .led        (led),
    .frame_done (frame_done),
    .err        (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // One beat on the next rising edge; returns 1 time unit after that edge.
  task automatic send(input logic [3:0] d, input logic sof, input logic bad_par = 1'b0);
    rx_valid = 1'b1;
    rx_data  = d;
    rx_sof   = sof;
`ifdef TDM_RX_PARITY_EN
    rx_par   = (^d) ^ bad_par;
`endif
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_sof   = 1'b0;
  endtask

  task automatic expect_done(input logic [15:0] v);
    done_t e;
    e.cyc = cyc;
    e.led = v;
    exp_done.push_back(e);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (frame_done) begin
        if (exp_done.size() == 0) begin
          check("unexpected_frame_done", {16'h0, led}, 32'hFFFF_FFFF);
        end else begin
          done_t e;
          e = exp_done.pop_front();
          check("frame_done_cycle", cyc, e.cyc);
          check("led_on_commit", {16'h0, led}, {16'h0, e.led});
        end
      end
      if (err) begin
        if (exp_err.size() == 0) begin
          check("unexpected_err", 32'd1, 32'd0);
        end else begin
          check("err_cycle", cyc, exp_err.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    en       = 1'b0;
    rx_valid = 1'b0;
    rx_sof   = 1'b0;
    rx_data  = 4'h0;
`ifdef TDM_RX_PARITY_EN
    rx_par   = 1'b0;
`endif
    idle(2);
    check("reset_led", {16'h0, led}, 32'h0);
    check("reset_frame_done", {31'h0, frame_done}, 32'h0);
    check("reset_err", {31'h0, err}, 32'h0);
    check("ready_follows_en_low", {31'h0, rx_ready}, 32'h0);
    reset = 1'b0;
    en    = 1'b1;
    #1;
    check("ready_follows_en_high", {31'h0, rx_ready}, 32'h1);
    idle(1);

    // Basic frame
    send(4'h9, 1'b1); send(4'h5, 1'b0); send(4'hA, 1'b0); send(4'h6, 1'b0);
    expect_done(16'h6A59);
    idle(2);

    // Sync error: second sof restarts the frame
    send(4'h3, 1'b1); send(4'hC, 1'b0);
    send(4'h7, 1'b1); exp_err.push_back(cyc);
    send(4'h1, 1'b0); send(4'h2, 1'b0);
    check("led_held_before_commit", {16'h0, led}, {16'h0, 16'h6A59});
    send(4'h4, 1'b0);
    expect_done(16'h4217);
    idle(2);

    // Beats without sof in HUNT are dropped silently
    send(4'h5, 1'b0); send(4'h5, 1'b0);
    send(4'hF, 1'b1); send(4'hE, 1'b0); send(4'hD, 1'b0); send(4'hC, 1'b0);
    expect_done(16'hCDEF);
    idle(2);

    // Pause mid-frame: offered sof beats while en=0 must be ignored
    send(4'h1, 1'b1); send(4'h2, 1'b0);
    en       = 1'b0;
    rx_valid = 1'b1;
    rx_sof   = 1'b1;
    rx_data  = 4'hF;
    repeat (5) begin
      #1;
      check("ready_low_in_pause", {31'h0, rx_ready}, 32'h0);
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    rx_sof   = 1'b0;
    en       = 1'b1;
    send(4'h3, 1'b0); send(4'h4, 1'b0);
    expect_done(16'h4321);
    idle(2);

    // Reset mid-frame clears led asynchronously
    send(4'h8, 1'b1); send(4'h8, 1'b0); send(4'h8, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_led", {16'h0, led}, 32'h0);
    idle(2);
    reset = 1'b0;
    idle(1);
    send(4'h1, 1'b1); send(4'h1, 1'b0); send(4'h1, 1'b0); send(4'h1, 1'b0);
    expect_done(16'h1111);

    // Back-to-back frames at full throughput
    send(4'h2, 1'b1); send(4'h3, 1'b0); send(4'h4, 1'b0); send(4'h5, 1'b0);
    expect_done(16'h5432);
    send(4'h6, 1'b1); send(4'h7, 1'b0); send(4'h8, 1'b0); send(4'h9, 1'b0);
    expect_done(16'h9876);
    idle(2);

`ifdef TDM_RX_PARITY_EN
    // Bad parity on slot 2: err, frame discarded, trailing beat dropped
    send(4'h1, 1'b1); send(4'h2, 1'b0);
    send(4'h3, 1'b0, 1'b1); exp_err.push_back(cyc);
    send(4'h4, 1'b0);
    idle(2);
    check("led_held_after_parity_err", {16'h0, led}, {16'h0, 16'h9876});
    // Bad parity on the final slot blocks the commit
    send(4'hA, 1'b1); send(4'hB, 1'b0); send(4'hC, 1'b0);
    send(4'hD, 1'b0, 1'b1); exp_err.push_back(cyc);
    idle(2);
    check("led_held_final_parity_err", {16'h0, led}, {16'h0, 16'h9876});
`endif

    idle(3);
    check("pending_frame_done", exp_done.size(), 32'd0);
    check("pending_err", exp_err.size(), 32'd0);
    check("final_led", {16'h0, led}, {16'h0, 16'h9876});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
